// File: rtl/serial_add_sub.sv
// rtl/serial_add_sub.sv - digit-serial two's-complement adder/subtractor
//
// Processes DIGIT bits per cycle through a DIGIT-bit full-adder chain,
// keeping the inter-digit carry in a flip-flop. N = WIDTH/DIGIT digit cycles.
//
// Ports:
//   clk    rising-edge clock
//   rst    synchronous active-high reset
//   start  request, accepted only in IDLE or DONE
//   sub    0: a+b, 1: a-b (sampled with start)
//   a, b   operands (sampled with start)
//   busy   high while digits are being processed
//   done   one-cycle pulse, result valid
//   s      registered result, held until the next completion
//   cout   carry out of the MSB (subtract: 1 = no borrow)
//   ovf    signed overflow of the operation
module serial_add_sub #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] acc;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             a_msb;
    logic             b_msb;

    logic             accept;
    logic             last_digit;
    logic [DIGIT-1:0] dsum;
    logic             dcarry;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH+DIGIT-1:0] acc_cat;

    assign last_digit = (cnt == CW'(N - 1));
    assign busy       = (state == ST_RUN);
    assign done       = (state == ST_DONE);

    // Ripple chain over the low digit of the shifting operand registers.
    always_comb begin : ripple
        logic c;
        c    = carry;
        dsum = '0;
        for (int i = 0; i < DIGIT; i++) begin
            dsum[i] = a_reg[i] ^ b_reg[i] ^ c;
            c       = (a_reg[i] & b_reg[i]) | (c & (a_reg[i] ^ b_reg[i]));
        end
        dcarry = c;
    end

    // New digit enters from the top so after N digits the LSB digit sits at bit 0.
    assign acc_cat  = {dsum, acc};
    assign acc_next = acc_cat[WIDTH+DIGIT-1:DIGIT];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (last_digit) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = ST_RUN;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg <= '0;
            b_reg <= '0;
            acc   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            s     <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else if (accept) begin
            // Subtraction as a + ~b + 1: the +1 rides in as the initial carry.
            a_reg <= a;
            b_reg <= sub ? ~b : b;
            carry <= sub;
            cnt   <= '0;
            a_msb <= a[WIDTH-1];
            b_msb <= sub ? ~b[WIDTH-1] : b[WIDTH-1];
        end else if (state == ST_RUN) begin
            acc   <= acc_next;
            a_reg <= a_reg >> DIGIT;
            b_reg <= b_reg >> DIGIT;
            carry <= dcarry;
            cnt   <= cnt + CW'(1);
            if (last_digit) begin
                s    <= acc_next;
                cout <= dcarry;
                ovf  <= (a_msb == b_msb) && (acc_next[WIDTH-1] != a_msb);
            end
        end
    end

endmodule
